// File: rtl/spike_pkg.sv
// Shared types and sizing helpers for the spike arbiter.
package spike_pkg;

  localparam int STATS_W = 16;
  localparam logic [STATS_W-1:0] STATS_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } spike_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int syn_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_arbiter_if.sv
// Per-source spike request bundle between requesters (master) and the arbiter (slave).
interface spike_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 2
);

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0]             src_ready;

  modport master (output src_valid, output src_addr, input src_ready);
  modport slave  (input src_valid, input src_addr, output src_ready);

endinterface

// File: rtl/spike_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible source at or after ptr_i wins.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     elig_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o,
  output logic [PTR_W-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest eligible source is kept last.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (elig_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        valid_o  = 1'b1;
        idx_o    = PTR_W'(j);
      end else begin
        gnt_o    = gnt_o;
      end
    end
  end

endmodule

// File: rtl/spike_arbiter.sv
// Round-robin spike arbiter with per-synapse dead time.
// Optional statistics counters are built when SPIKE_ARBITER_STATS_EN is defined.
module spike_arbiter
  import spike_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int NUM_SYN     = 2,
  parameter int DEAD_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 stats_clr_i,
  spike_arbiter_if.slave       src_if,
  output logic [NUM_SYN-1:0]   input_spike_o,
  output logic                 addr_err_o,
  output logic                 busy_o,
  output logic [STATS_W-1:0]   grant_count_o,
  output logic [STATS_W-1:0]   stall_count_o
);

  localparam int SYN_W = syn_w(NUM_SYN);
  // One extra address bit so out-of-range targets can actually be requested.
  localparam int ADDR_W = SYN_W + 1;
  localparam int PTR_W  = syn_w(NUM_SRC);
  localparam int CNT_W  = syn_w(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);
  localparam logic [0:0] S_RUN    = ST_RUN;
  localparam logic [0:0] S_PAUSED = ST_PAUSED;

  logic [0:0]                      state_q, state_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_SYN-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SYN-1:0]              spike_q, spike_d;
  logic                            err_q, err_d;
  logic                            busy_q, busy_d;

  logic [NUM_SRC-1:0][ADDR_W-1:0]  addr_s;
  logic [NUM_SRC-1:0]              elig_s;
  logic [NUM_SRC-1:0]              pick_s;
  logic                            pick_valid_s;
  logic [PTR_W-1:0]                pick_idx_s;
  logic                            run_s;
  logic                            grant_s;
  logic [ADDR_W-1:0]               gaddr_s;
  logic [SYN_W-1:0]                gsyn_s;
  logic                            in_range_s;

  assign addr_s = src_if.src_addr;

  // Eligibility: valid and target synapse idle; out-of-range targets never wait.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!src_if.src_valid[i]) begin
        elig_s[i] = 1'b0;
      end else if (addr_s[i] >= ADDR_W'(NUM_SYN)) begin
        elig_s[i] = 1'b1;
      end else begin
        elig_s[i] = (cnt_q[addr_s[i][SYN_W-1:0]] == '0);
      end
    end
  end

  rr_pick #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .elig_i  (elig_s),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_s),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Ready is forced low during reset so nothing is accepted while the arbiter is held.
  assign run_s      = (state_q == S_RUN) && reset;
  assign grant_s    = pick_valid_s && run_s;
  assign gaddr_s    = addr_s[pick_idx_s];
  assign gsyn_s     = gaddr_s[SYN_W-1:0];
  assign in_range_s = (gaddr_s < ADDR_W'(NUM_SYN));
  assign src_if.src_ready = pick_s & {NUM_SRC{run_s}};

  // Next-state: FSM follows en, dead-time counters tick down, grants launch pulses.
  always_comb begin
    state_d = en_i ? S_RUN : S_PAUSED;
    spike_d = '0;
    err_d   = 1'b0;
    for (int j = 0; j < NUM_SYN; j++) begin
      if (cnt_q[j] != '0) begin
        cnt_d[j] = cnt_q[j] - CNT_W'(1);
      end else begin
        cnt_d[j] = '0;
      end
    end
    if (grant_s) begin
      if (pick_idx_s == PTR_W'(NUM_SRC - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx_s + PTR_W'(1);
      end
      if (in_range_s) begin
        spike_d[gsyn_s] = 1'b1;
        cnt_d[gsyn_s]   = DEAD_CNT;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      ptr_d = ptr_q;
    end
    busy_d = (|cnt_d) || (|spike_d);
  end

  // Core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      spike_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign input_spike_o = spike_q;
  assign addr_err_o    = err_q;
  assign busy_o        = busy_q;

`ifdef SPIKE_ARBITER_STATS_EN
  logic [STATS_W-1:0] grant_cnt_q;
  logic [STATS_W-1:0] stall_cnt_q;
  logic               stall_s;

  assign stall_s = (|src_if.src_valid) && !grant_s;

  // Saturating statistics; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (stats_clr_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_s && (grant_cnt_q != STATS_MAX)) begin
        grant_cnt_q <= grant_cnt_q + STATS_W'(1);
      end
      if (stall_s && (stall_cnt_q != STATS_MAX)) begin
        stall_cnt_q <= stall_cnt_q + STATS_W'(1);
      end
    end
  end

  assign grant_count_o = grant_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  logic unused_stats_clr_s;
  assign unused_stats_clr_s = stats_clr_i;
  assign grant_count_o = '0;
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_spike_arbiter.sv
// Self-checking bench: directed table on a 4-synapse/no-dead-time instance, model-checked
// sequences and random traffic on a 2-synapse/DEAD_CYCLES=3 instance.
module tb_spike_arbiter;
  import spike_pkg::*;

  localparam int NSRC   = 4;
  localparam int A_AW   = 3;
  localparam int B_SYN  = 2;
  localparam int B_AW   = 2;
  localparam int B_DEAD = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en_a, en_b, stats_clr;
  logic [3:0]  spike_a;
  logic [1:0]  spike_b;
  logic        err_a, err_b, busy_a, busy_b;
  logic [15:0] gc_a, sc_a, gc_b, sc_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spike_arbiter_if #(.NUM_SRC(NSRC), .ADDR_W(A_AW)) if_a ();
  spike_arbiter_if #(.NUM_SRC(NSRC), .ADDR_W(B_AW)) if_b ();

  spike_arbiter #(.NUM_SRC(NSRC), .NUM_SYN(4), .DEAD_CYCLES(0)) u_a (
    .clk(clk), .reset(reset), .en_i(en_a), .stats_clr_i(stats_clr), .src_if(if_a),
    .input_spike_o(spike_a), .addr_err_o(err_a), .busy_o(busy_a),
    .grant_count_o(gc_a), .stall_count_o(sc_a)
  );

  spike_arbiter #(.NUM_SRC(NSRC), .NUM_SYN(B_SYN), .DEAD_CYCLES(B_DEAD)) u_b (
    .clk(clk), .reset(reset), .en_i(en_b), .stats_clr_i(stats_clr), .src_if(if_b),
    .input_spike_o(spike_b), .addr_err_o(err_b), .busy_o(busy_b),
    .grant_count_o(gc_b), .stall_count_o(sc_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model of instance B: tracks the cycle of each synapse's last spike.
  int         m_cyc;
  int         m_last [B_SYN];
  int         m_ptr;
  bit         m_run;
  logic [1:0] m_spike;
  bit         m_err;
  int         m_gc, m_sc;

  task automatic model_reset();
    m_cyc = 0; m_ptr = 0; m_run = 1'b1; m_spike = 2'b00; m_err = 1'b0;
    m_gc = 0; m_sc = 0;
    for (int s = 0; s < B_SYN; s++) m_last[s] = -100;
  endtask

  function automatic int sat16(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  // One cycle on instance B: drive, compare with the model, advance the model.
  task automatic cyc_b(input logic [3:0] v, input logic [3:0][1:0] a, input logic en,
                       input string tag, output logic [3:0] gnt);
    logic [3:0] exp_rdy;
    bit exp_busy;
    int g, ai, i;
    @(negedge clk);
    if_b.src_valid = v;
    if_b.src_addr  = a;
    en_b = en;
    #1;
    exp_busy = (m_spike != 2'b00);
    for (int s = 0; s < B_SYN; s++)
      if (m_cyc >= m_last[s] + 1 && m_cyc <= m_last[s] + B_DEAD) exp_busy = 1'b1;
    g = -1;
    if (m_run) begin
      for (int k = 0; k < NSRC; k++) begin
        i = (m_ptr + k) % NSRC;
        if (g < 0 && v[i]) begin
          ai = int'(a[i]);
          if (ai >= B_SYN || (m_cyc - m_last[ai]) > B_DEAD) g = i;
        end
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check({tag, "_ready"}, 32'(if_b.src_ready), 32'(exp_rdy));
    check({tag, "_spike"}, 32'(spike_b), 32'(m_spike));
    check({tag, "_err"},   32'(err_b), 32'(m_err));
    check({tag, "_busy"},  32'(busy_b), 32'(exp_busy));
`ifdef SPIKE_ARBITER_STATS_EN
    check({tag, "_gcnt"}, 32'(gc_b), 32'(sat16(m_gc)));
    check({tag, "_scnt"}, 32'(sc_b), 32'(sat16(m_sc)));
`else
    check({tag, "_gcnt"}, 32'(gc_b), 32'd0);
    check({tag, "_scnt"}, 32'(sc_b), 32'd0);
`endif
    m_spike = 2'b00;
    m_err   = 1'b0;
    if (g >= 0) begin
      ai = int'(a[g]);
      if (ai < B_SYN) begin
        m_spike[ai] = 1'b1;
        m_last[ai]  = m_cyc;
      end else begin
        m_err = 1'b1;
      end
      m_ptr = (g + 1) % NSRC;
      m_gc++;
    end else if (v != 4'b0000) begin
      m_sc++;
    end
    if (stats_clr) begin
      m_gc = 0;
      m_sc = 0;
    end
    m_run = en;
    m_cyc++;
    gnt = exp_rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    if_a.src_valid = 4'b0000; if_a.src_addr = '0;
    if_b.src_valid = 4'b0000; if_b.src_addr = '0;
    en_a = 1'b1; en_b = 1'b1; stats_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0]      v;
    logic [3:0][2:0] a;
    logic [3:0]      rdy;
    logic [3:0]      spk;
    logic            err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gnt;
    logic [3:0] cur_v;
    logic [3:0][1:0] cur_a;
    logic [3:0] seen;

    // Reset state, with requests present so ready must stay low.
    en_a = 1'b1; en_b = 1'b1; stats_clr = 1'b0;
    if_a.src_valid = 4'b1111; if_a.src_addr = '0;
    if_b.src_valid = 4'b1111; if_b.src_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_a", 32'(if_a.src_ready), 32'd0);
    check("rst_ready_b", 32'(if_b.src_ready), 32'd0);
    check("rst_spike_a", 32'(spike_a), 32'd0);
    check("rst_spike_b", 32'(spike_b), 32'd0);
    check("rst_err",     32'({err_a, err_b}), 32'd0);
    check("rst_busy",    32'({busy_a, busy_b}), 32'd0);
    check("rst_stats",   {gc_b, sc_b}, 32'd0);

    // Directed table on instance A (4 synapses, no dead time).
    tbl[0] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0001, 4'b0000, 1'b0};
    tbl[1] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0010, 4'b0001, 1'b0};
    tbl[2] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0100, 4'b0010, 1'b0};
    tbl[3] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b1000, 4'b0100, 1'b0};
    tbl[4] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0001, 4'b1000, 1'b0};
    tbl[5] = '{4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 4'b0001, 1'b0};
    tbl[6] = '{4'b0110, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0010, 4'b0000, 1'b0};
    tbl[7] = '{4'b0100, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0100, 4'b0010, 1'b0};
    tbl[8] = '{4'b1001, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b1000, 4'b0100, 1'b0};
    tbl[9] = '{4'b0000, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b0000, 4'b0000, 1'b1};
    do_reset();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      if_a.src_valid = tbl[r].v;
      if_a.src_addr  = tbl[r].a;
      #1;
      check($sformatf("tbl%0d_ready", r), 32'(if_a.src_ready), 32'(tbl[r].rdy));
      check($sformatf("tbl%0d_spike", r), 32'(spike_a), 32'(tbl[r].spk));
      check($sformatf("tbl%0d_err", r),   32'(err_a), 32'(tbl[r].err));
      check($sformatf("tbl%0d_busy", r),  32'(busy_a), 32'(|tbl[r].spk));
    end

    // Continuous request to synapse 1: pulses at cycles 1, 5, 9.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      cyc_b(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 1'b1, "r33", gnt);
      check($sformatf("r33_pulse%0d", c), 32'(spike_b),
            (c == 1 || c == 5 || c == 9) ? 32'd2 : 32'd0);
    end

    // Blocked source skipped in favour of a free one in the same cycle.
    do_reset();
    cyc_b(4'b1000, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b1, "r34a", gnt);
    cyc_b(4'b0011, {2'd0, 2'd0, 2'd1, 2'd0}, 1'b1, "r34b", gnt);
    check("r34_skip", 32'(gnt), 32'd2);
    cyc_b(4'b0000, '0, 1'b1, "r34c", gnt);

    // Out-of-range address: accepted, then error pulse without a spike.
    do_reset();
    cyc_b(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 1'b1, "r35a", gnt);
    check("r35_ready", 32'(if_b.src_ready), 32'd4);
    cyc_b(4'b0000, '0, 1'b1, "r35b", gnt);
    check("r35_err", 32'({err_b, spike_b}), 32'd4);

    // Pause window: en low in cycles 5..9 blocks grants 6..10, pointer preserved.
    do_reset();
    seen = 4'b0000;
    for (int c = 0; c < 13; c++) begin
      cyc_b(4'b1111, {2'd3, 2'd2, 2'd3, 2'd2}, !(c >= 5 && c < 10), "r36", gnt);
      if (c >= 6 && c <= 10) seen = seen | gnt;
      if (c == 5)  check("r36_last", 32'(gnt), 32'd2);
      if (c == 11) check("r36_resume", 32'(gnt), 32'd4);
    end
    check("r36_paused", 32'(seen), 32'd0);

    // Reset in the middle of a pulse clears it immediately and nothing follows.
    do_reset();
    cyc_b(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 1'b1, "r27a", gnt);
    @(posedge clk);
    #2;
    check("r27_pulse", 32'(spike_b), 32'd2);
    reset = 1'b0;
    #1;
    check("r27_clear", 32'({spike_b, busy_b, if_b.src_ready}), 32'd0);
    do_reset();
    cyc_b(4'b0000, '0, 1'b1, "r27b", gnt);
    cyc_b(4'b0000, '0, 1'b1, "r27c", gnt);

    // Random traffic against the model; pending requests hold their address.
    do_reset();
    cur_v = 4'b0000;
    cur_a = '0;
    gnt   = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!(cur_v[i] && !gnt[i])) begin
          cur_v[i] = ($urandom_range(0, 2) != 0);
          cur_a[i] = 2'($urandom_range(0, 3));
        end
      end
      cyc_b(cur_v, cur_a, ($urandom_range(0, 7) != 0), "rnd", gnt);
    end

`ifdef SPIKE_ARBITER_STATS_EN
    // Stall counter saturation and clear.
    do_reset();
    @(negedge clk);
    if_b.src_valid = 4'b0001;
    en_b = 1'b0;
    repeat (70000) @(negedge clk);
    #1;
    check("stats_sat", 32'(sc_b), 32'h0000FFFF);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    check("stats_clr", {gc_b, sc_b}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
